// File: rtl/move_recorder_pkg.sv
// Shared definitions for the move recorder: direction codes, default stack depth, FSM states.
`default_nettype none

package move_recorder_pkg;

   typedef enum logic [1:0] {
      UP    = 2'b00,
      DOWN  = 2'b01,
      RIGHT = 2'b10,
      LEFT  = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RECORD = 2'b01,
      DONE   = 2'b10
   } state_t;

   localparam int MAX_MOVES_DEF = 17;

endpackage

`default_nettype wire

// File: rtl/move_recorder.sv
// Move stack feeding the display: packs engine moves into ord, supports pop/replace, freezes on fin.
// Optional REVERSE_REJECT_EN: refuse a push that undoes the current top move.
`default_nettype none

module move_recorder
   import move_recorder_pkg::*;
#(
   parameter int MAX_MOVES = MAX_MOVES_DEF,
   parameter int CNT_W     = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   mv_valid,
   input  logic [1:0]             mv_dir,
   output logic                   mv_ready,
   input  logic                   pop,
   input  logic                   fin,
   output logic [2*MAX_MOVES-1:0] ord,
   output logic [CNT_W-1:0]       cnt,
   output logic                   comp,
   output logic                   err
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_MOVES);

   state_t           state;
   logic             err_sticky;
   logic             recording;
   logic             room;
   logic             base_ready;
   logic             push;
   logic             do_replace;
   logic             do_push;
   logic             do_pop;
   logic             pop_empty;
   logic             drop_full;
   logic             do_write;
   logic [CNT_W-1:0] cnt_m1;
   logic [CNT_W-1:0] wr_idx;

   assign recording  = (state == RECORD);
   assign room       = (cnt < FULL);
   assign base_ready = recording && room;
   assign cnt_m1     = cnt - 1'b1;

`ifdef REVERSE_REJECT_EN
   logic                   err_rev;
   logic                   reverse_hit;
   logic                   rev_reject;
   logic [2*MAX_MOVES-1:0] ord_shifted;

   assign ord_shifted = ord >> {cnt_m1, 1'b0};
   assign reverse_hit = (cnt != '0) && (mv_dir == (ord_shifted[1:0] ^ 2'b01));
   // Replace (push with pop) overwrites the top, so undoing it is legitimate.
   assign mv_ready    = base_ready && (!reverse_hit || pop);
   assign rev_reject  = base_ready && mv_valid && reverse_hit && !pop;
   assign err         = err_sticky | err_rev;
`else
   assign mv_ready    = base_ready;
   assign err         = err_sticky;
`endif

   assign push       = mv_valid && mv_ready;
   assign do_replace = push && pop && (cnt != '0);
   assign do_push    = push && !do_replace;
   assign do_pop     = recording && pop && !push && (cnt != '0);
   assign pop_empty  = recording && pop && !push && (cnt == '0);
   assign drop_full  = recording && mv_valid && !room && !pop;
   assign do_write   = do_replace || do_push;
   assign wr_idx     = do_replace ? cnt_m1 : cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         comp       <= 1'b0;
         err_sticky <= 1'b0;
`ifdef REVERSE_REJECT_EN
         err_rev    <= 1'b0;
`endif
      end else if (start) begin
         state      <= RECORD;
         cnt        <= '0;
         comp       <= 1'b0;
         err_sticky <= 1'b0;
`ifdef REVERSE_REJECT_EN
         err_rev    <= 1'b0;
`endif
      end else begin
`ifdef REVERSE_REJECT_EN
         err_rev <= rev_reject;
`endif
         case (state)
            RECORD: begin
               if (do_push) begin
                  cnt <= cnt + 1'b1;
               end else if (do_pop) begin
                  cnt <= cnt_m1;
               end
               if (pop_empty || drop_full) begin
                  err_sticky <= 1'b1;
               end
               if (fin) begin
                  state <= DONE;
                  comp  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // One 2-bit register per stack slot; slots above cnt are kept at zero.
   for (genvar i = 0; i < MAX_MOVES; i++) begin : g_slot
      logic [1:0] slot;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot <= 2'b00;
         end else if (start) begin
            slot <= 2'b00;
         end else if (do_write && (wr_idx == CNT_W'(i))) begin
            slot <= mv_dir;
         end else if (do_pop && (cnt_m1 == CNT_W'(i))) begin
            slot <= 2'b00;
         end
      end

      assign ord[2*i +: 2] = slot;
   end

endmodule

`default_nettype wire
